// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes the immediate format of a raw instruction and emits the extended immediate one cycle later.
// Build option IMMGEN_ZICSR_EN adds CSR zimm decoding (type 7) for SYSTEM funct3 101/110/111.
module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [31:0]     out_instr
);
    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_SH   = 3'd2;
    localparam logic [2:0] T_S    = 3'd3;
    localparam logic [2:0] T_B    = 3'd4;
    localparam logic [2:0] T_U    = 3'd5;
    localparam logic [2:0] T_J    = 3'd6;
    localparam logic [2:0] T_Z    = 3'd7;

    logic [6:0]      opc;
    logic            sh_f3;
    logic [2:0]      sys_type;
    logic [2:0]      dec_type;
    logic [5:0]      shamt;
    logic [XLEN-1:0] dec_imm;
    logic            accept;
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_type;
    logic [31:0]     skid_instr;

    assign opc   = in_instr[6:0];
    assign sh_f3 = in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101;

`ifdef IMMGEN_ZICSR_EN
    assign sys_type = (in_instr[14] && in_instr[13:12] != 2'b00) ? T_Z : T_NONE;
`else
    assign sys_type = T_NONE;
`endif

    assign dec_type = (opc == 7'b0000011 || opc == 7'b1100111) ? T_I :
                      (opc == 7'b0010011) ? (sh_f3 ? T_SH : T_I) :
                      (opc == 7'b0100011) ? T_S :
                      (opc == 7'b1100011) ? T_B :
                      (opc == 7'b0110111 || opc == 7'b0010111) ? T_U :
                      (opc == 7'b1101111) ? T_J :
                      (opc == 7'b0011011 && XLEN == 64) ? (sh_f3 ? T_SH : T_I) :
                      (opc == 7'b1110011) ? sys_type : T_NONE;

    // Only RV64 OP-IMM gets the 6-bit shamt; funct7 bits above it are masked off.
    assign shamt = (XLEN == 64 && opc == 7'b0010011) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

    assign dec_imm = (dec_type == T_I)  ? XLEN'($signed(in_instr[31:20])) :
                     (dec_type == T_SH) ? XLEN'(shamt) :
                     (dec_type == T_S)  ? XLEN'($signed({in_instr[31:25], in_instr[11:7]})) :
                     (dec_type == T_B)  ? XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                                         in_instr[11:8], 1'b0})) :
                     (dec_type == T_U)  ? XLEN'($signed({in_instr[31:12], 12'b0})) :
                     (dec_type == T_J)  ? XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                                         in_instr[30:21], 1'b0})) :
                     (dec_type == T_Z)  ? XLEN'(in_instr[19:15]) : '0;

    assign accept = in_valid && in_ready;

    // in_ready is registered as "skid will be empty next cycle", so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_type   <= T_NONE;
            out_instr  <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_type  <= T_NONE;
            skid_instr <= '0;
            in_ready   <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || out_ready) begin
            out_valid  <= skid_valid || accept;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            if (skid_valid) begin
                out_imm   <= skid_imm;
                out_type  <= skid_type;
                out_instr <= skid_instr;
            end else if (accept) begin
                out_imm   <= dec_imm;
                out_type  <= dec_type;
                out_instr <= in_instr;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_type  <= dec_type;
            skid_instr <= in_instr;
            in_ready   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed scoreboard bench for imm_gen_pipe (XLEN=32 main instance, XLEN=64 side instance).
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_imm, out_instr;
    logic [2:0]  out_type;
    logic        in_ready64, out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_type64;
    logic [31:0] out_instr64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   w;

    imm_gen_pipe #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_type(out_type), .out_instr(out_instr)
    );

    imm_gen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64),
        .out_type(out_type64), .out_instr(out_instr64)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] m, input logic [2:0] t, output int waited);
        in_valid = 1'b1;
        in_instr = i;
        waited = 0;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        chk("accept", 64'(in_ready), 64'd1);
        sb.push_back('{i, m, t});
        step();
        in_valid = 1'b0;
    endtask

    // Pop and compare on the cycle before each output transfer edge.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL extra_out: observed=%h expected=none", out_instr);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("out_instr", 64'(out_instr), 64'(e.instr));
                chk("out_imm", 64'(out_imm), 64'(e.imm));
                chk("out_type", 64'(out_type), 64'(e.typ));
            end
        end
    end

    initial begin
        #1 rstn = 1'b0;
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_type", 64'(out_type), 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        rstn = 1'b1;
        step();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, w);
        chk("lat1_valid", 64'(out_valid), 64'd1);
        step();
        chk("lat1_empty", 64'(out_valid), 64'd0);

        send(32'hFE000EE3, 32'hFFFFFFFC, 3'd4, w);
        chk("b2b_v1", 64'(out_valid), 64'd1);
        send(32'h12345037, 32'h12345000, 3'd5, w);
        chk("b2b_v2", 64'(out_valid), 64'd1);
        chk("b2b_wait2", 64'(w), 64'd0);
        send(32'h0080006F, 32'h00000008, 3'd6, w);
        chk("b2b_v3", 64'(out_valid), 64'd1);
        chk("b2b_wait3", 64'(w), 64'd0);

        send(32'h01F09093, 32'h0000001F, 3'd2, w);
        send(32'h4030D093, 32'h00000003, 3'd2, w);
        send(32'h03F09093, 32'h0000001F, 3'd2, w);
        chk("x64_shamt_imm", out_imm64, 64'h3F);
        chk("x64_shamt_type", 64'(out_type64), 64'd2);
        send(32'h0000001B, 32'h00000000, 3'd0, w);
        chk("x64_opimm32_imm", out_imm64, 64'h0);
        chk("x64_opimm32_type", 64'(out_type64), 64'd1);
        send(32'h80000037, 32'h80000000, 3'd5, w);
        chk("x64_lui_imm", out_imm64, 64'hFFFFFFFF80000000);
        send(32'h00112423, 32'h00000008, 3'd3, w);
        send(32'hFE112E23, 32'hFFFFFFFC, 3'd3, w);
        send(32'h00412083, 32'h00000004, 3'd1, w);
        send(32'h000080E7, 32'h00000000, 3'd1, w);
        send(32'hFFFFF097, 32'hFFFFF000, 3'd5, w);
        send(32'h002081B3, 32'h00000000, 3'd0, w);
        send(32'h30029073, 32'h00000000, 3'd0, w);
`ifdef IMMGEN_ZICSR_EN
        send(32'h3002D073, 32'h00000005, 3'd7, w);
`else
        send(32'h3002D073, 32'h00000000, 3'd0, w);
`endif
        step();

        out_ready = 1'b0;
        send(32'h00500093, 32'h00000005, 3'd1, w);
        send(32'h00C0006F, 32'h0000000C, 3'd6, w);
        chk("full_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_instr = 32'h00112423;
        step();
        step();
        chk("full_ready_hold", 64'(in_ready), 64'd0);
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_instr", 64'(out_instr), 64'h00500093);
        out_ready = 1'b1;
        send(32'h00112423, 32'h00000008, 3'd3, w);
        chk("third_wait", 64'(w), 64'd1);
        step();
        chk("drain_sb", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, w);
        send(32'h12345037, 32'h12345000, 3'd5, w);
        in_valid = 1'b1;
        in_instr = 32'h0080006F;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        sb.delete();
        out_ready = 1'b1;
        repeat (3) step();
        chk("flush_dropped", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        send(32'h00500093, 32'h00000005, 3'd1, w);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_imm", 64'(out_imm), 64'd0);
        chk("arst_type", 64'(out_type), 64'd0);
        chk("arst_instr", 64'(out_instr), 64'd0);
        sb.delete();
        rstn = 1'b1;
        step();
        chk("arst_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, w);
        step();
        chk("final_sb", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
